// File: rtl/bruteforce_controller.sv
// bruteforce_controller: sequences the candidate generator and masked-compares against the target; ATTEMPT_COUNT_EN adds a saturating attempts counter.
// Latency: start to first compare 2 cycles, found one cycle after the matching compare; no backpressure, the generator advances every RUN cycle.
module bruteforce_controller #(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = 5
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [MAX_LEN*8-1:0] target,
  input  logic [LEN_W-1:0]     target_len,
  input  logic [7:0]           start_char,
  input  logic [2:0]           increment,
  output logic                 gen_clear,
  output logic                 gen_enable,
  output logic [7:0]           gen_start_char,
  output logic [2:0]           gen_increment,
  output logic [LEN_W-1:0]     gen_length,
  input  logic [MAX_LEN*8-1:0] gen_candidate,
  input  logic                 gen_last,
  output logic                 busy,
  output logic                 found,
  output logic                 exhausted,
  output logic [MAX_LEN*8-1:0] password,
  output logic [31:0]          attempts
);

  typedef enum logic [2:0] {IDLE, CLEAR, RUN, FOUND, EXHAUST} state_t;

  state_t               state, state_nxt;
  logic [MAX_LEN*8-1:0] target_q;
  logic                 len_ok, match, accept;

  assign len_ok = (target_len != '0) && (target_len <= LEN_W'(MAX_LEN));

  // Bytes at or beyond the latched length never affect the result.
  always_comb begin
    match = 1'b1;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((LEN_W'(i) < gen_length) && (gen_candidate[i*8 +: 8] != target_q[i*8 +: 8]))
        match = 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE, FOUND, EXHAUST: begin
          if (start && len_ok) begin
            accept    = 1'b1;
            state_nxt = CLEAR;
          end
        end
        CLEAR:   state_nxt = RUN;
        RUN: begin
          if (match)         state_nxt = FOUND;
          else if (gen_last) state_nxt = EXHAUST;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      target_q       <= '0;
      gen_length     <= '0;
      gen_start_char <= '0;
      gen_increment  <= '0;
      password       <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        target_q       <= target;
        gen_length     <= target_len;
        gen_start_char <= start_char;
        gen_increment  <= increment;
      end
      if (!abort && (state == RUN) && match)
        password <= gen_candidate;
    end
  end

  assign gen_clear  = (state == CLEAR);
  assign gen_enable = (state == RUN);
  assign busy       = (state == CLEAR) || (state == RUN);
  assign found      = (state == FOUND);
  assign exhausted  = (state == EXHAUST);

`ifdef ATTEMPT_COUNT_EN
  logic [31:0] attempts_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      attempts_q <= '0;
    else if (abort || (state == CLEAR))
      attempts_q <= '0;
    else if ((state == RUN) && (attempts_q != 32'hFFFF_FFFF))
      attempts_q <= attempts_q + 32'd1;
  end

  assign attempts = attempts_q;
`else
  assign attempts = '0;
`endif

endmodule
